// File: rtl/keypad_scanner_pkg.sv
// Shared constants, state encoding and row-decode helpers for the keypad scanner.
package keypad_scanner_pkg;

    localparam int unsigned NUM_ROWS  = 4;
    localparam int unsigned NUM_COLS  = 4;
    localparam int unsigned KEY_W     = 4;
    localparam int unsigned ROW_IDX_W = 2;
    localparam int unsigned COL_IDX_W = 2;
    localparam int unsigned STATE_W   = 2;

    localparam logic [NUM_COLS-1:0] COL_RESET = 4'b1110;

    // Scanner FSM encoding
    localparam logic [STATE_W-1:0] ST_SCAN     = 2'd0;
    localparam logic [STATE_W-1:0] ST_DEBOUNCE = 2'd1;
    localparam logic [STATE_W-1:0] ST_HELD     = 2'd2;
    localparam logic [STATE_W-1:0] ST_RELEASE  = 2'd3;

    // True when exactly one active-low row line is asserted
    function automatic logic single_low(input logic [NUM_ROWS-1:0] rows);
        int unsigned lows;
        lows = 0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) lows++;
        end
        return (lows == 1);
    endfunction

    // Index of the (last) low row line; only meaningful when single_low() holds
    function automatic logic [ROW_IDX_W-1:0] low_row_index(input logic [NUM_ROWS-1:0] rows);
        logic [ROW_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < NUM_ROWS; i++) begin
            if (!rows[i]) idx = ROW_IDX_W'(i);
        end
        return idx;
    endfunction

    // Active-low one-hot strobe for a column index
    function automatic logic [NUM_COLS-1:0] col_strobe(input logic [COL_IDX_W-1:0] idx);
        logic [NUM_COLS-1:0] strobe;
        strobe      = '1;
        strobe[idx] = 1'b0;
        return strobe;
    endfunction

endpackage

// File: rtl/keypad_scanner_if.sv
// Key handoff between the scanner and the calculator core (valid/ack plus status).
interface keypad_scanner_if import keypad_scanner_pkg::*; ();

    logic [KEY_W-1:0] Key_code;
    logic             Key_valid;
    logic             Key_ack;
    logic             Key_held;
    logic             Overrun;

    modport master (
        output Key_code,
        output Key_valid,
        output Key_held,
        output Overrun,
        input  Key_ack
    );

    modport slave (
        input  Key_code,
        input  Key_valid,
        input  Key_held,
        input  Overrun,
        output Key_ack
    );

endinterface

// File: rtl/scan_tick_gen.sv
// Prescaler producing a one-cycle Tick every SCAN_DIV clocks.
module scan_tick_gen #(
    parameter int unsigned SCAN_DIV = 50000
) (
    input  logic Clock,
    input  logic Reset_n,
    output logic Tick
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(SCAN_DIV - 1);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    // Wrap at the terminal count
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (count_q == LAST) count_d = '0;
    end

    // Tick is registered so it is high exactly while count sits at LAST
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            count_q <= '0;
            Tick    <= 1'b0;
        end else begin
            count_q <= count_d;
            Tick    <= (count_d == LAST);
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad column scanner with press/release debounce and valid/ack key handoff.
module keypad_scanner import keypad_scanner_pkg::*; #(
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEBOUNCE_SCANS = 3
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic [NUM_ROWS-1:0]  Row,
    output logic [NUM_COLS-1:0]  Col,
    keypad_scanner_if.master     key_bus
);

    localparam int unsigned CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_SCANS);

    logic                 tick;
    logic [NUM_ROWS-1:0]  row_meta;
    logic [NUM_ROWS-1:0]  row_sync;

    logic [STATE_W-1:0]   state_q,   state_d;
    logic [COL_IDX_W-1:0] col_idx_q, col_idx_d;
    logic [ROW_IDX_W-1:0] row_idx_q, row_idx_d;
    logic [CNT_W-1:0]     count_q,   count_d;
    logic [NUM_COLS-1:0]  col_q,     col_d;
    logic [KEY_W-1:0]     code_q,    code_d;
    logic                 valid_q,   valid_d;
    logic                 held_q,    held_d;
    logic                 overrun_q, overrun_d;

    logic                 press;
    logic [ROW_IDX_W-1:0] press_row;
    logic                 all_released;
    logic                 accept;
    logic                 advance;

    scan_tick_gen #(
        .SCAN_DIV (SCAN_DIV)
    ) u_tick (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Tick    (tick)
    );

    // Two-flop synchronizer for the asynchronous row lines
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            row_meta <= '1;
            row_sync <= '1;
        end else begin
            row_meta <= Row;
            row_sync <= row_meta;
        end
    end

    // Next-state, debounce, column stepping and handshake logic
    always_comb begin
        state_d   = state_q;
        col_idx_d = col_idx_q;
        row_idx_d = row_idx_q;
        count_d   = count_q;
        held_d    = held_q;
        code_d    = code_q;
        valid_d   = valid_q;
        overrun_d = overrun_q;
        accept    = 1'b0;
        advance   = 1'b0;

        press        = single_low(row_sync);
        press_row    = low_row_index(row_sync);
        all_released = (row_sync == '1);

        if (tick) begin
            case (state_q)
                ST_SCAN: begin
                    if (press) begin
                        row_idx_d = press_row;
                        count_d   = CNT_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end else begin
                            state_d = ST_DEBOUNCE;
                        end
                    end else begin
                        advance = 1'b1;
                    end
                end
                ST_DEBOUNCE: begin
                    if (press && (press_row == row_idx_q)) begin
                        count_d = count_q + CNT_ONE;
                        if (count_d == CNT_DONE) begin
                            accept  = 1'b1;
                            state_d = ST_HELD;
                        end
                    end else begin
                        state_d = ST_SCAN;
                        advance = 1'b1;
                    end
                end
                ST_HELD: begin
                    if (all_released) begin
                        count_d = CNT_ONE;
                        if (DEBOUNCE_SCANS == 1) begin
                            held_d  = 1'b0;
                            state_d = ST_SCAN;
                            advance = 1'b1;
                        end else begin
                            state_d = ST_RELEASE;
                        end
                    end
                end
                ST_RELEASE: begin
                    if (all_released) begin
                        count_d = count_q + CNT_ONE;
                        if (count_d == CNT_DONE) begin
                            held_d  = 1'b0;
                            state_d = ST_SCAN;
                            advance = 1'b1;
                        end
                    end else begin
                        state_d = ST_HELD;
                    end
                end
                default: begin
                    state_d = ST_SCAN;
                end
            endcase
        end

        if (advance) col_idx_d = col_idx_q + COL_IDX_W'(1);

        // A fresh accept always wins over a same-cycle ack
        if (accept) begin
            code_d  = {row_idx_d, col_idx_q};
            valid_d = 1'b1;
            held_d  = 1'b1;
            if (valid_q && !key_bus.Key_ack) overrun_d = 1'b1;
        end else if (valid_q && key_bus.Key_ack) begin
            valid_d = 1'b0;
        end

        col_d = col_strobe(col_idx_d);
    end

    // State and output registers
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_q   <= ST_SCAN;
            col_idx_q <= '0;
            row_idx_q <= '0;
            count_q   <= '0;
            col_q     <= COL_RESET;
            code_q    <= '0;
            valid_q   <= 1'b0;
            held_q    <= 1'b0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            col_idx_q <= col_idx_d;
            row_idx_q <= row_idx_d;
            count_q   <= count_d;
            col_q     <= col_d;
            code_q    <= code_d;
            valid_q   <= valid_d;
            held_q    <= held_d;
            overrun_q <= overrun_d;
        end
    end

    assign Col               = col_q;
    assign key_bus.Key_code  = code_q;
    assign key_bus.Key_valid = valid_q;
    assign key_bus.Key_held  = held_q;
    assign key_bus.Overrun   = overrun_q;

endmodule
